// File: rtl/pkt_fifo_pkg.sv
// pkt_fifo_pkg
//   Shared definitions for the frame-aware packet FIFO controller.
//   state_t : write-side FSM encoding (idle, frame open, discarding).
package pkt_fifo_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FRAME   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

endpackage

// File: rtl/pkt_fifo_ctrl_if.sv
// pkt_fifo_ctrl_if
//   Writer/reader handshake bundle for pkt_fifo_ctrl.
//   Write side : i_wr_valid, o_wr_ready, i_wr_data, i_wr_last, i_wr_drop
//   Read side  : o_rd_valid, i_rd_ready, o_rd_data, o_rd_last
//   Status     : o_count (committed unread entries), o_ovf (overflow pulse)
//   modport master : frame writer + reader (drives the i_* signals)
//   modport slave  : the FIFO controller (drives the o_* signals)
interface pkt_fifo_ctrl_if #(
    parameter int ASIZE = 3,
    parameter int DSIZE = 8
);
    logic             i_wr_valid;
    logic             o_wr_ready;
    logic [DSIZE-1:0] i_wr_data;
    logic             i_wr_last;
    logic             i_wr_drop;
    logic             o_rd_valid;
    logic             i_rd_ready;
    logic [DSIZE-1:0] o_rd_data;
    logic             o_rd_last;
    logic [ASIZE:0]   o_count;
    logic             o_ovf;

    modport master (
        output i_wr_valid, i_wr_data, i_wr_last, i_wr_drop, i_rd_ready,
        input  o_wr_ready, o_rd_valid, o_rd_data, o_rd_last, o_count, o_ovf
    );

    modport slave (
        input  i_wr_valid, i_wr_data, i_wr_last, i_wr_drop, i_rd_ready,
        output o_wr_ready, o_rd_valid, o_rd_data, o_rd_last, o_count, o_ovf
    );
endinterface

// File: rtl/pkt_fifo_ctrl_dualram.sv
// dualram
//   Simple dual-port RAM: one synchronous write port, one asynchronous
//   (combinational) read port. Contents are not reset.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write address, wr_data : write word
//   rd_addr : read address,  rd_data : read word (same-cycle)
module dualram #(
    parameter int ASIZE = 3,
    parameter int DSIZE = 9
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [ASIZE-1:0] wr_addr,
    input  logic [DSIZE-1:0] wr_data,
    input  logic [ASIZE-1:0] rd_addr,
    output logic [DSIZE-1:0] rd_data
);
    logic [DSIZE-1:0] mem [0:(1<<ASIZE)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/pkt_fifo_ctrl.sv
// pkt_fifo_ctrl
//   Frame-aware FIFO controller around one dualram. Beats become visible to
//   the reader only once their frame is committed with last; frames can be
//   dropped by the writer or discarded automatically on overflow.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : pkt_fifo_ctrl_if.slave (write/read handshakes, count, ovf)
module pkt_fifo_ctrl
    import pkt_fifo_pkg::*;
#(
    parameter int ASIZE = 3,
    parameter int DSIZE = 8
) (
    input logic            i_clk,
    input logic            i_rst_n,
    pkt_fifo_ctrl_if.slave bus
);
    localparam logic [ASIZE:0] DEPTH_V  = {1'b1, {ASIZE{1'b0}}};
    localparam logic [ASIZE:0] OPEN_MAX = {1'b0, {ASIZE{1'b1}}};
    localparam logic [ASIZE:0] PTR_ONE  = {{ASIZE{1'b0}}, 1'b1};

    state_t         state;
    logic [ASIZE:0] wr_ptr;
    logic [ASIZE:0] cm_ptr;
    logic [ASIZE:0] rd_ptr;
    logic [ASIZE:0] fill;
    logic [ASIZE:0] open_len;
    logic [ASIZE:0] count;
    logic           ovf;
    logic           full;
    logic           wr_ready;
    logic           rd_valid;
    logic           wh;
    logic           rh;
    logic           in_frame;
    logic           ovf_hit;
    logic           keep_beat;
    logic [DSIZE:0] rd_word;

    assign fill     = wr_ptr - rd_ptr;
    assign open_len = wr_ptr - cm_ptr;
    assign count    = cm_ptr - rd_ptr;
    assign full     = (fill == DEPTH_V);

    // Ready depends only on registered pointers/state, never on i_rd_ready.
    assign wr_ready = !full || (state == S_DISCARD);
    assign rd_valid = (count != '0);

    assign wh       = bus.i_wr_valid && wr_ready;
    assign rh       = rd_valid && bus.i_rd_ready;
    assign in_frame = (state != S_DISCARD);

    // A non-terminating beat arriving when the open frame already holds
    // DEPTH-1 beats can never be committed, so the frame is abandoned.
    assign ovf_hit   = wh && in_frame && !bus.i_wr_drop && !bus.i_wr_last &&
                       (open_len == OPEN_MAX);
    assign keep_beat = wh && in_frame && !bus.i_wr_drop && !ovf_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            cm_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (rh) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wh) begin
                case (state)
                    S_DISCARD: begin
                        if (bus.i_wr_last || bus.i_wr_drop) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        if (bus.i_wr_drop) begin
                            wr_ptr <= cm_ptr;
                            state  <= S_IDLE;
                        end else if (bus.i_wr_last) begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                            cm_ptr <= wr_ptr + PTR_ONE;
                            state  <= S_IDLE;
                        end else if (ovf_hit) begin
                            wr_ptr <= cm_ptr;
                            ovf    <= 1'b1;
                            state  <= S_DISCARD;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                            state  <= S_FRAME;
                        end
                    end
                endcase
            end
        end
    end

    dualram #(
        .ASIZE(ASIZE),
        .DSIZE(DSIZE + 1)
    ) u_ram (
        .clk     (i_clk),
        .wr_en   (keep_beat),
        .wr_addr (wr_ptr[ASIZE-1:0]),
        .wr_data ({bus.i_wr_last, bus.i_wr_data}),
        .rd_addr (rd_ptr[ASIZE-1:0]),
        .rd_data (rd_word)
    );

    assign bus.o_wr_ready = wr_ready;
    assign bus.o_rd_valid = rd_valid;
    assign bus.o_rd_data  = rd_word[DSIZE-1:0];
    assign bus.o_rd_last  = rd_word[DSIZE];
    assign bus.o_count    = count;
    assign bus.o_ovf      = ovf;
endmodule

// File: tb/tb_pkt_fifo_ctrl.sv
// tb_pkt_fifo_ctrl
//   Directed self-checking bench for pkt_fifo_ctrl with ASIZE=3, DSIZE=8.
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pkt_fifo_ctrl;
    localparam int ASIZE = 3;
    localparam int DSIZE = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   test_count = 0;
    int   fail_count = 0;
    int   ovf_pulses = 0;

    pkt_fifo_ctrl_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) bus();

    pkt_fifo_ctrl #(.ASIZE(ASIZE), .DSIZE(DSIZE)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_ovf) ovf_pulses++;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Offer one write beat and hold it until accepted (bounded).
    task automatic applyStimulus(input logic [7:0] data, input logic last, input logic drop);
        int waited = 0;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = data;
        bus.i_wr_last  = last;
        bus.i_wr_drop  = drop;
        while (!bus.o_wr_ready && waited < 100) begin
            stepCycle();
            waited++;
        end
        if (!bus.o_wr_ready) checkOutput("wr_ready_timeout", int'(bus.o_wr_ready), 1);
        stepCycle();
        bus.i_wr_valid = 1'b0;
        bus.i_wr_last  = 1'b0;
        bus.i_wr_drop  = 1'b0;
    endtask

    // Wait (bounded) for a committed beat, check it, then consume it.
    task automatic expectBeat(input logic [7:0] data, input logic last, input string tag);
        int waited = 0;
        while (!bus.o_rd_valid && waited < 100) begin
            stepCycle();
            waited++;
        end
        checkOutput({tag, "_valid"}, int'(bus.o_rd_valid), 1);
        checkOutput({tag, "_data"}, int'(bus.o_rd_data), int'(data));
        checkOutput({tag, "_last"}, int'(bus.o_rd_last), int'(last));
        bus.i_rd_ready = 1'b1;
        stepCycle();
        bus.i_rd_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ovf_base;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_data  = '0;
        bus.i_wr_last  = 1'b0;
        bus.i_wr_drop  = 1'b0;
        bus.i_rd_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) stepCycle();
        checkOutput("rst_rd_valid", int'(bus.o_rd_valid), 0);
        checkOutput("rst_wr_ready", int'(bus.o_wr_ready), 1);
        checkOutput("rst_count", int'(bus.o_count), 0);
        checkOutput("rst_ovf", int'(bus.o_ovf), 0);
        rst_n = 1'b1;
        stepCycle();

        // Commit: frame invisible until last, then visible right after the edge
        applyStimulus(8'hA1, 1'b0, 1'b0);
        applyStimulus(8'hA2, 1'b0, 1'b0);
        checkOutput("commit_pre_valid", int'(bus.o_rd_valid), 0);
        applyStimulus(8'hA3, 1'b1, 1'b0);
        checkOutput("commit_valid", int'(bus.o_rd_valid), 1);
        checkOutput("commit_count", int'(bus.o_count), 3);
        expectBeat(8'hA1, 1'b0, "commit_b0");
        expectBeat(8'hA2, 1'b0, "commit_b1");
        expectBeat(8'hA3, 1'b1, "commit_b2");
        checkOutput("commit_empty", int'(bus.o_rd_valid), 0);

        // Drop: nothing of the dropped frame is visible
        applyStimulus(8'h11, 1'b0, 1'b0);
        applyStimulus(8'h12, 1'b0, 1'b0);
        applyStimulus(8'h13, 1'b0, 1'b1);
        checkOutput("drop_count", int'(bus.o_count), 0);
        checkOutput("drop_valid", int'(bus.o_rd_valid), 0);
        applyStimulus(8'h21, 1'b1, 1'b0);
        checkOutput("drop_next_count", int'(bus.o_count), 1);
        expectBeat(8'h21, 1'b1, "drop_next");
        checkOutput("drop_empty", int'(bus.o_rd_valid), 0);

        // Full: 8-beat frame fills all entries
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'(i), 1'(i == 7), 1'b0);
        end
        checkOutput("full_wr_ready", int'(bus.o_wr_ready), 0);
        checkOutput("full_count", int'(bus.o_count), 8);
        expectBeat(8'h00, 1'b0, "full_b0");
        checkOutput("full_ready_back", int'(bus.o_wr_ready), 1);
        checkOutput("full_count_7", int'(bus.o_count), 7);
        for (int i = 1; i < 8; i++) begin
            expectBeat(8'(i), 1'(i == 7), "full_drain");
        end
        checkOutput("full_empty", int'(bus.o_rd_valid), 0);

        // Overflow: 10-beat frame is discarded, ovf pulses once after beat 8
        ovf_base = ovf_pulses;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(8'(8'hC0 + i), 1'(i == 10), 1'b0);
            if (i == 7) begin
                checkOutput("ovf_b7_count", int'(bus.o_count), 0);
                checkOutput("ovf_b7_flag", int'(bus.o_ovf), 0);
            end
            if (i == 8) begin
                checkOutput("ovf_b8_flag", int'(bus.o_ovf), 1);
                checkOutput("ovf_b8_ready", int'(bus.o_wr_ready), 1);
            end
            if (i == 9) checkOutput("ovf_b9_flag", int'(bus.o_ovf), 0);
        end
        checkOutput("ovf_count", int'(bus.o_count), 0);
        checkOutput("ovf_valid", int'(bus.o_rd_valid), 0);
        checkOutput("ovf_pulses", ovf_pulses - ovf_base, 1);
        applyStimulus(8'hB1, 1'b0, 1'b0);
        applyStimulus(8'hB2, 1'b1, 1'b0);
        checkOutput("ovf_next_count", int'(bus.o_count), 2);
        expectBeat(8'hB1, 1'b0, "ovf_next_b0");
        expectBeat(8'hB2, 1'b1, "ovf_next_b1");

        // Reset mid-frame with a committed frame also pending
        applyStimulus(8'h70, 1'b1, 1'b0);
        applyStimulus(8'h33, 1'b0, 1'b0);
        applyStimulus(8'h34, 1'b0, 1'b0);
        checkOutput("mid_pre_count", int'(bus.o_count), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", int'(bus.o_rd_valid), 0);
        checkOutput("mid_rst_ready", int'(bus.o_wr_ready), 1);
        checkOutput("mid_rst_count", int'(bus.o_count), 0);
        checkOutput("mid_rst_ovf", int'(bus.o_ovf), 0);
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
        applyStimulus(8'h55, 1'b1, 1'b0);
        checkOutput("mid_after_count", int'(bus.o_count), 1);
        expectBeat(8'h55, 1'b1, "mid_after");
        checkOutput("mid_after_empty", int'(bus.o_rd_valid), 0);

        // Wrap + concurrency: 20 three-beat frames with the reader always ready
        fork
            begin
                for (int f = 0; f < 20; f++) begin
                    for (int b = 0; b < 3; b++) begin
                        applyStimulus(8'(f * 3 + b), 1'(b == 2), 1'b0);
                    end
                end
            end
            begin
                int idx = 0;
                int cycles = 0;
                int max_count = 0;
                bus.i_rd_ready = 1'b1;
                while (idx < 60 && cycles < 1000) begin
                    if (int'(bus.o_count) > max_count) max_count = int'(bus.o_count);
                    if (bus.o_rd_valid) begin
                        checkOutput("stream_data", int'(bus.o_rd_data), idx);
                        checkOutput("stream_last", int'(bus.o_rd_last), int'(idx % 3 == 2));
                        idx++;
                    end
                    stepCycle();
                    cycles++;
                end
                bus.i_rd_ready = 1'b0;
                checkOutput("stream_total", idx, 60);
                checkOutput("stream_count_le8", int'(max_count <= 8), 1);
            end
        join
        checkOutput("stream_empty", int'(bus.o_rd_valid), 0);
        checkOutput("stream_count_end", int'(bus.o_count), 0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end
endmodule
